sensor_input_conditioner: RTL and testbench
===========================================

# sensor_input_conditioner

Front-end stage that conditions every raw board input before it reaches the irrigation top level. It synchronises the six field sensors and two push-buttons to `clock`, debounces each channel with its own counter, and emits clean sensor levels. It also converts button presses into the single-cycle `pulse_3` / `pulse_2` strobes consumed by the column/display selectors and the timer reset logic. A one-cycle `sensor_changed` strobe flags any change in a debounced sensor level.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised input must differ from its stable value before the stable value flips. Legal range is 1..65535.
- `clock`  in  1  single system clock; every flop uses its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `raw_low_water_level`, `raw_mid_water_level`, `raw_high_water_level`  in  1 each  raw float switches, active-high, asynchronous.
- `raw_earth_humidity`, `raw_air_humidity`, `raw_low_temperature`  in  1 each  raw sensor inputs, active-high, asynchronous.
- `raw_button_3`, `raw_button_2`  in  1 each  raw push-buttons, active-low (0 = pressed), asynchronous.
- `low_water_level`, `mid_water_level`, `high_water_level`  out  1 each  debounced levels, registered.
- `earth_humidity`, `air_humidity`, `low_temperature`  out  1 each  debounced levels, registered.
- `pulse_3`, `pulse_2`  out  1 each  one-cycle active-high strobe per press.
- `sensor_changed`  out  1  one-cycle strobe when any of the six sensor outputs changes.

## Operation
- Channels: 8 identical debounce lanes, 6 sensor lanes and 2 button lanes. Lanes share no state.
- Synchroniser: each raw input passes through 2 flops, `sync1` then `sync2`.
- Debounce lane state:
  - `stable`: 1 bit.
  - `count`: width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned, never wraps.
- Lane update, once per clock edge:
  - If `sync2 == stable`: `count <= 0`.
  - Else if `count == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `count <= 0`.
  - Else: `count <= count+1`.
- Glitch handling: any single cycle with `sync2 == stable` restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the outputs.
- Sensor outputs equal their lane's `stable`, driven straight from the flop with no extra logic.
- Button lanes:
  - `stable` is held in released polarity: 1 = released.
  - Each lane keeps a `stable_d` register, a one-cycle-delayed copy of `stable`.
  - `pulse_x = stable_d & ~stable`, registered: a one-cycle pulse on the press edge.
  - Release produces no pulse. Holding a button produces exactly one pulse.
- `sensor_changed`, registered: 1 for one cycle after any sensor lane's `stable` toggles. Simultaneous toggles on several lanes still give one single-cycle strobe.

## Timing
- Reset (async assert, `reset_n` = 0):
  - Sensor `sync1`/`sync2`/`stable` = 0; all `count` = 0.
  - Button `sync1`/`sync2`/`stable`/`stable_d` = 1.
  - All outputs = 0.
- Reset release: internal flops resume on the first rising edge after `reset_n` goes high. A button held through reset gives no pulse until it is released and pressed again.
- Latency: raw input stable from before edge E (edge E captures it into `sync1`).
  - `sync2` shows the new value after edge E+1.
  - `stable` and the sensor output change at edge E+1+`DEBOUNCE_CYCLES`.
  - `pulse_x` and `sensor_changed` assert at edge E+2+`DEBOUNCE_CYCLES` and last exactly one cycle.
- `DEBOUNCE_CYCLES` = 1: a lane flips on the first differing `sync2` sample.
- Reset mid-count: lanes return to reset values immediately and in-flight counts are discarded. No pulse or strobe is generated by reset itself.
- Simultaneous button presses: each button lane pulses independently, possibly in the same cycle.

## Test plan
- Reset values: hold `reset_n`=0 with arbitrary raw inputs, release, keep raw sensors = 0 and buttons = 1 → all outputs 0 for 100 cycles.
- Clean sensor edge: `DEBOUNCE_CYCLES`=16, set `raw_mid_water_level`=1 before edge 10.
  - `mid_water_level` rises at edge 27.
  - `sensor_changed` is high for exactly one cycle, at edge 28.
- Glitch rejection: toggle `raw_earth_humidity` high for 15 cycles, low for 1, high for 15 → `earth_humidity` stays 0 throughout and `sensor_changed` never asserts.
- Button press: drive `raw_button_3`=0 and hold for 200 cycles, then release → `pulse_3` high for exactly one cycle at E+18; no further pulse during the hold or on release; `pulse_2` stays 0.
- Simultaneous events: flip all three water raw inputs and press both buttons on the same edge.
  - All three water outputs change on the same edge.
  - `sensor_changed` is one single-cycle strobe.
  - `pulse_3` and `pulse_2` assert together for one cycle.
- Reset mid-count: start a `raw_air_humidity` rise, assert `reset_n`=0 at count 10, release with the input still high → output stays 0 until a full 16-cycle run after release.

Source files
------------

// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
// Synchronises and debounces the six field sensors and two push-buttons,
// presents clean sensor levels, turns button presses into one-cycle strobes
// and flags any change of a debounced sensor level with a one-cycle strobe.
//
// Lane numbering used throughout:
//   0 low_water_level, 1 mid_water_level, 2 high_water_level,
//   3 earth_humidity,  4 air_humidity,    5 low_temperature,
//   6 button_3,        7 button_2
// Button lanes stay in released polarity (1 = released), so their reset value
// is 1 while sensor lanes reset to 0.
//
// A button that is already held when reset releases must not produce a press
// strobe until it has been seen released. Each button lane therefore carries
// an arm bit that is set by the first genuine released sample after reset
// (the valid shift register marks when sync2 holds a real sample rather than
// its reset value).
module sensor_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_low_water_level,
  input  logic raw_mid_water_level,
  input  logic raw_high_water_level,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  input  logic raw_button_3,
  input  logic raw_button_2,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic pulse_3,
  output logic pulse_2,
  output logic sensor_changed
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LastCount = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LaneResetVal = 8'hC0;

  logic [7:0]    rawVec;
  logic [7:0]    sync1_q;
  logic [7:0]    sync2_q;
  logic [1:0]    valid_q;
  logic [7:0]    stable_q;
  logic [7:0]    stable_d;
  logic [7:0]    stableDly_q;
  logic [CW-1:0] count_q [8];
  logic [CW-1:0] count_d [8];
  logic [1:0]    armed_q;
  logic [1:0]    armed_d;
  logic [1:0]    pulse_q;
  logic [1:0]    pulse_d;
  logic          changed_q;
  logic          changed_d;

  assign rawVec = {raw_button_2, raw_button_3, raw_low_temperature,
                   raw_air_humidity, raw_earth_humidity, raw_high_water_level,
                   raw_mid_water_level, raw_low_water_level};

  // Two-flop synchroniser per lane, plus a marker of when sync2 holds real samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= LaneResetVal;
      sync2_q <= LaneResetVal;
      valid_q <= '0;
    end else begin
      sync1_q <= rawVec;
      sync2_q <= sync1_q;
      valid_q <= {valid_q[0], 1'b1};
    end
  end

  // Debounce next state: count consecutive differing samples, flip after DEBOUNCE_CYCLES
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      count_d[i] = count_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        count_d[i] = '0;
      end else if (count_q[i] == LastCount) begin
        stable_d[i] = sync2_q[i];
        count_d[i]  = '0;
      end else begin
        count_d[i] = count_q[i] + CW'(1);
      end
    end
  end

  // Debounce lane registers and the one-cycle-delayed copy used for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q    <= LaneResetVal;
      stableDly_q <= LaneResetVal;
      for (int i = 0; i < 8; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      for (int i = 0; i < 8; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  // Strobe next state: press edges on armed buttons, any toggle on sensor lanes
  always_comb begin
    armed_d   = armed_q | ({2{valid_q[1]}} & sync2_q[7:6]);
    pulse_d   = armed_q & stableDly_q[7:6] & ~stable_q[7:6];
    changed_d = |(stableDly_q[5:0] ^ stable_q[5:0]);
  end

  // Registered strobes and button arm bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= '0;
      pulse_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      pulse_q   <= pulse_d;
      changed_q <= changed_d;
    end
  end

  assign low_water_level  = stable_q[0];
  assign mid_water_level  = stable_q[1];
  assign high_water_level = stable_q[2];
  assign earth_humidity   = stable_q[3];
  assign air_humidity     = stable_q[4];
  assign low_temperature  = stable_q[5];
  assign pulse_3          = pulse_q[0];
  assign pulse_2          = pulse_q[1];
  assign sensor_changed   = changed_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: two instances (DEBOUNCE_CYCLES 16 and 1)
// are driven with the same inputs and compared every cycle against a model
// that keeps the raw sample history since reset and decides flips by looking
// at the last DEBOUNCE_CYCLES synchronised samples. Directed scenarios add
// literal expectations at hand-computed edges.
module tb_sensor_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] rawDrive;
  wire  [8:0] out16;
  wire  [8:0] out1;

  int vectors = 0;
  int miscompares = 0;

  localparam int MaxLog = 8192;
  bit [7:0] rawLog [MaxLog];
  int       logLen = 0;
  bit [7:0] resetVal = 8'hC0;
  int       dval [2] = '{16, 1};
  bit [7:0] mStable [2];
  bit [7:0] flipPrev [2];
  bit [7:0] fellPrev [2];
  bit [1:0] armed;
  bit [8:0] expOut [2];

  always #5 clock = ~clock;

  sensor_input_conditioner #(.DEBOUNCE_CYCLES(16)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .raw_low_water_level(rawDrive[0]), .raw_mid_water_level(rawDrive[1]),
    .raw_high_water_level(rawDrive[2]), .raw_earth_humidity(rawDrive[3]),
    .raw_air_humidity(rawDrive[4]), .raw_low_temperature(rawDrive[5]),
    .raw_button_3(rawDrive[6]), .raw_button_2(rawDrive[7]),
    .low_water_level(out16[0]), .mid_water_level(out16[1]),
    .high_water_level(out16[2]), .earth_humidity(out16[3]),
    .air_humidity(out16[4]), .low_temperature(out16[5]),
    .sensor_changed(out16[6]), .pulse_3(out16[7]), .pulse_2(out16[8])
  );

  sensor_input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .raw_low_water_level(rawDrive[0]), .raw_mid_water_level(rawDrive[1]),
    .raw_high_water_level(rawDrive[2]), .raw_earth_humidity(rawDrive[3]),
    .raw_air_humidity(rawDrive[4]), .raw_low_temperature(rawDrive[5]),
    .raw_button_3(rawDrive[6]), .raw_button_2(rawDrive[7]),
    .low_water_level(out1[0]), .mid_water_level(out1[1]),
    .high_water_level(out1[2]), .earth_humidity(out1[3]),
    .air_humidity(out1[4]), .low_temperature(out1[5]),
    .sensor_changed(out1[6]), .pulse_3(out1[7]), .pulse_2(out1[8])
  );

  task automatic checkOutput(input string name, input logic [8:0] actual,
                             input logic [8:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a raw input vector, then advance the given number of edges and settle 2 ns.
  task automatic applyStimulus(input logic [7:0] value, input int cycles);
    rawDrive = value;
    repeat (cycles) @(posedge clock);
    #2;
  endtask

  // Synchronised sample seen by the lanes: before the first real sample the
  // synchroniser holds the reset value.
  function automatic bit sampleAt(input int idx, input int lane);
    if (idx < 0) return resetVal[lane];
    return rawLog[idx][lane];
  endfunction

  task automatic modelReset();
    logLen = 0;
    armed  = '0;
    for (int s = 0; s < 2; s++) begin
      mStable[s]  = resetVal;
      flipPrev[s] = '0;
      fellPrev[s] = '0;
      expOut[s]   = '0;
    end
  endtask

  // One rising edge: the sample captured two edges ago is the newest one the
  // lanes can see; a lane flips when its last DEBOUNCE_CYCLES visible samples
  // all disagree with its current level.
  task automatic modelEdge();
    bit [7:0] flip;
    bit       allDiffer;
    for (int b = 0; b < 2; b++)
      if (logLen >= 3 && rawLog[logLen-3][6+b]) armed[b] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      expOut[s][7] = fellPrev[s][6] & armed[0];
      expOut[s][8] = fellPrev[s][7] & armed[1];
      expOut[s][6] = |flipPrev[s][5:0];
      flip = '0;
      for (int lane = 0; lane < 8; lane++) begin
        allDiffer = 1'b1;
        for (int j = 0; j < dval[s]; j++)
          if (sampleAt(logLen - 2 - j, lane) == mStable[s][lane]) allDiffer = 1'b0;
        flip[lane] = allDiffer;
      end
      fellPrev[s]      = flip & mStable[s];
      flipPrev[s]      = flip;
      mStable[s]       = mStable[s] ^ flip;
      expOut[s][5:0]   = mStable[s][5:0];
    end
    if (logLen >= MaxLog) begin
      $display("[TB] FAIL modelLog: history full at %0d samples", logLen);
      $fatal(1, "[TB] model history exhausted");
    end
    rawLog[logLen] = rawDrive;
    logLen++;
  endtask

  // Compare process: update the model on every edge, check both instances 1 ns later
  always @(posedge clock) begin
    if (!reset_n) modelReset();
    else modelEdge();
    #1;
    checkOutput("model16", out16, expOut[0]);
    checkOutput("model1", out1, expOut[1]);
  end

  initial begin : stimulus
    logic [7:0] cur;
    logic [7:0] v;
    bit         sawEarth;
    bit         sawChanged;
    int         pulses3;
    int         pulses2;
    int         firstPulse;
    int         phaseLen [4] = '{15, 1, 15, 20};
    bit         phaseOn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset_n  = 1'b0;
    rawDrive = 8'($urandom);
    repeat (5) @(posedge clock);
    #2;
    applyStimulus(8'($urandom), 2);
    applyStimulus(8'hC0, 2);
    reset_n = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(8'hC0, 1);
      checkOutput("idle16", out16, 9'h000);
      checkOutput("idle1", out1, 9'h000);
    end

    $display("[TB] clean sensor edge");
    cur = 8'hC2;
    applyStimulus(cur, 1);
    checkOutput("d1MidAtE", {8'h00, out1[1]}, 9'h000);
    applyStimulus(cur, 1);
    checkOutput("d1MidAtE1", {8'h00, out1[1]}, 9'h000);
    applyStimulus(cur, 1);
    checkOutput("d1MidAtE2", {8'h00, out1[1]}, 9'h001);
    applyStimulus(cur, 14);
    checkOutput("midAtE16", {8'h00, out16[1]}, 9'h000);
    applyStimulus(cur, 1);
    checkOutput("midAtE17", {7'h00, out16[6], out16[1]}, 9'h001);
    applyStimulus(cur, 1);
    checkOutput("changedAtE18", {8'h00, out16[6]}, 9'h001);
    applyStimulus(cur, 1);
    checkOutput("changedAtE19", {8'h00, out16[6]}, 9'h000);
    applyStimulus(cur, 10);

    $display("[TB] glitch rejection");
    sawEarth   = 1'b0;
    sawChanged = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < phaseLen[p]; c++) begin
        applyStimulus(phaseOn[p] ? (cur | 8'h08) : cur, 1);
        sawEarth   |= out16[3];
        sawChanged |= out16[6];
      end
    end
    checkOutput("glitchEarth", {8'h00, sawEarth}, 9'h000);
    checkOutput("glitchChanged", {8'h00, sawChanged}, 9'h000);

    $display("[TB] button press and hold");
    pulses3    = 0;
    pulses2    = 0;
    firstPulse = 0;
    v = cur & 8'hBF;
    applyStimulus(v, 1);
    for (int c = 1; c <= 250; c++) begin
      applyStimulus((c <= 200) ? v : cur, 1);
      if (out16[7]) begin
        pulses3++;
        if (firstPulse == 0) firstPulse = c;
      end
      if (out16[8]) pulses2++;
    end
    checkOutput("pulse3Count", 9'(pulses3), 9'd1);
    checkOutput("pulse3Edge", 9'(firstPulse), 9'd18);
    checkOutput("pulse2Count", 9'(pulses2), 9'd0);

    $display("[TB] simultaneous events");
    v = 8'h05;
    applyStimulus(v, 1);
    applyStimulus(v, 16);
    checkOutput("waterAtE16", {6'h00, out16[2:0]}, 9'h002);
    applyStimulus(v, 1);
    checkOutput("waterAtE17", {6'h00, out16[2:0]}, 9'h005);
    checkOutput("strobesAtE17", {6'h00, out16[8:6]}, 9'h000);
    applyStimulus(v, 1);
    checkOutput("strobesAtE18", {6'h00, out16[8:6]}, 9'h007);
    applyStimulus(v, 1);
    checkOutput("strobesAtE19", {6'h00, out16[8:6]}, 9'h000);
    cur = 8'hC5;
    applyStimulus(cur, 40);

    $display("[TB] reset during a count");
    v = cur | 8'h10;
    applyStimulus(v, 1);
    applyStimulus(v, 11);
    reset_n = 1'b0;
    #1;
    checkOutput("asyncReset", out16, 9'h000);
    applyStimulus(v, 2);
    reset_n = 1'b1;
    applyStimulus(v, 17);
    checkOutput("airAfterReset17", {8'h00, out16[4]}, 9'h000);
    applyStimulus(v, 1);
    checkOutput("airAfterReset18", {8'h00, out16[4]}, 9'h001);
    applyStimulus(v, 20);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      v = rawDrive;
      for (int lane = 0; lane < 8; lane++)
        if ($urandom_range(0, 11) == 0) v[lane] = ~v[lane];
      applyStimulus(v, 1);
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        applyStimulus(rawDrive, int'($urandom_range(1, 3)));
        reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
